// File: rtl/ps2_keyboard_port_if.sv
// Bus-side bundle for the PS/2 keyboard port: raw PS/2 pins plus the
// register read strobe/select and the read response.
interface ps2_keyboard_port_if;
  logic        ps2_clk;
  logic        ps2_dat;
  logic        read_data;
  logic        addr;
  logic [15:0] data_out;
  logic        data_done;
  logic        irq_pending;

  // Environment side: drives the pins and the read requests
  modport master (
    output ps2_clk, ps2_dat, read_data, addr,
    input  data_out, data_done, irq_pending
  );

  // Port side: receives frames and answers register reads
  modport slave (
    input  ps2_clk, ps2_dat, read_data, addr,
    output data_out, data_done, irq_pending
  );
endinterface

// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard receiver with scancode FIFO and a two-register read port
// (0 = DATA, 1 = STATUS). Define PS2_PARITY_CHECK_EN to drop frames with
// bad (even) parity and report them through the sticky ParErr flag.
module ps2_keyboard_port #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                clk,
  input logic                rst_n,
  ps2_keyboard_port_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Synchronizers and edge detector
  logic clk_s1, clk_s2, clk_q;
  logic dat_s1, dat_s2;
  logic fall;

  // Receiver
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          push_pend;
  logic [7:0]    push_byte;
  logic          perr_pend;
  logic          parity_ok;

  // FIFO and register file
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          empty, full, do_pop, do_push, ovf_set, status_rd;
  logic          overflow, par_err;
  logic [15:0]   data_out_q;
  logic          data_done_q, irq_q;

  assign fall      = clk_q & ~clk_s2;
  assign parity_ok = !PARITY_CHECK || (^{shift, par_bit});

  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign do_pop     = bus.read_data & ~bus.addr & ~empty;
  assign do_push    = push_pend & (~full | do_pop);
  assign ovf_set    = push_pend & full & ~do_pop;
  assign status_rd  = bus.read_data & bus.addr;
  assign count_next = count + CW'(do_push) - CW'(do_pop);

  assign bus.data_out    = data_out_q;
  assign bus.data_done   = data_done_q;
  assign bus.irq_pending = irq_q;

  // Two-flop synchronizers (idle bus level on reset) plus edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Frame receiver FSM with inactivity timeout; a good frame raises push_pend for one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      push_pend <= 1'b0;
      push_byte <= '0;
      perr_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      perr_pend <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);

      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2) begin
              if (parity_ok) begin
                push_pend <= 1'b1;
                push_byte <= shift;
              end else begin
                perr_pend <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset since pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers, sticky flags and registered read response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      par_err     <= 1'b0;
      data_out_q  <= 16'h0000;
      data_done_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      data_done_q <= bus.read_data;
      if (bus.read_data) begin
        if (!bus.addr) data_out_q <= empty ? 16'h0000 : {1'b1, 7'b0, mem[rd_ptr]};
        else           data_out_q <= {overflow, par_err, 7'b0, 7'(count)};
      end
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count    <= count_next;
      irq_q    <= (count_next != '0);
      // a new event in the same cycle as a STATUS read survives the clear
      overflow <= (overflow & ~status_rd) | ovf_set;
      par_err  <= (par_err & ~status_rd) | perr_pend;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Directed bench for ps2_keyboard_port with a queue-based reference model
// and a per-cycle output comparison. Honours PS2_PARITY_CHECK_EN.
module tb_ps2_keyboard_port;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 300;
  localparam int          HALF  = 4;
  // pin change at cycle P reaches the FIFO at the rising edge of cycle P+4
  localparam int          PUSH_LAT = 4;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         at;
    logic [7:0] v;
    bit         ok;
    bit         perr;
  } sched_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ps2_keyboard_port_if bus();

  ps2_keyboard_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stop = -1;

  // reference model state
  logic [7:0]  q[$];
  sched_t      sched[$];
  bit          m_ovf, m_perr;
  logic [15:0] exp_out;
  bit          exp_done, exp_irq;
  bit          live = 1'b0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic odd_par(logic [7:0] d);
    return ~^d;
  endfunction

  // Reference model: register-level behaviour evaluated at each rising edge
  always @(posedge clk) begin
    bit rd, a, pop, psh, pe_set;
    logic [7:0] pv;
    sched_t e;
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      sched.delete();
      m_ovf = 0; m_perr = 0;
      exp_out = 16'h0000; exp_done = 0; exp_irq = 0;
      live = 1'b1;
    end else begin
      rd = bus.read_data; a = bus.addr;
      pop = rd && !a && (q.size() != 0);
      psh = 0; pe_set = 0; pv = 8'h00;
      if (sched.size() != 0 && sched[0].at == cyc) begin
        e = sched.pop_front();
        psh = e.ok; pe_set = e.perr; pv = e.v;
      end
      exp_done = rd;
      if (rd) begin
        if (!a) exp_out = (q.size() != 0) ? {8'h80, q[0]} : 16'h0000;
        else    exp_out = {m_ovf, m_perr, 7'b0, 7'(q.size())};
      end
      if (rd && a) begin m_ovf = 0; m_perr = 0; end
      if (pop) void'(q.pop_front());
      if (psh) begin
        if (q.size() < DEPTH) q.push_back(pv);
        else m_ovf = 1;
      end
      if (pe_set) m_perr = 1;
      exp_irq = (q.size() != 0);
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (live) begin
      check("data_done", 16'(bus.data_done), 16'(exp_done));
      check("data_out", bus.data_out, exp_out);
      check("irq_pending", 16'(bus.irq_pending), 16'(exp_irq));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ps2_bit(bit b);
    bus.ps2_dat = b;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_partial(logic [7:0] d, int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    bus.ps2_dat = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit par, bit stop);
    sched_t e;
    bit good_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    bus.ps2_dat = stop;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    last_stop = cyc;
    good_par = (^{d, par}) == 1'b1;
    e.at = cyc + PUSH_LAT; e.v = d;
    e.ok = stop && (!PAR_EN || good_par);
    e.perr = stop && PAR_EN && !good_par;
    if (e.ok || e.perr) sched.push_back(e);
    tick(HALF);
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic do_read(bit a, logic [15:0] exp, string name);
    bus.addr = a;
    bus.read_data = 1'b1;
    @(posedge clk); #1;
    bus.read_data = 1'b0;
    @(negedge clk);
    check({name, "_done"}, 16'(bus.data_done), 16'h0001);
    check(name, bus.data_out, exp);
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    bus.read_data = 1'b0;
    bus.addr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_data_done", 16'(bus.data_done), 16'h0000);
    check("rst_irq", 16'(bus.irq_pending), 16'h0000);
    rst_n = 1'b1;
    tick(2);

    // single frame 0x1C, read it back, interrupt drops
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    check("irq_after_frame", 16'(bus.irq_pending), 16'h0001);
    do_read(1'b0, 16'h801C, "rd_1c");
    check("irq_after_read", 16'(bus.irq_pending), 16'h0000);
    do_read(1'b1, 16'h0000, "status_idle");

    // bad-parity frame
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b1);
    do_read(1'b1, 16'h4000, "status_parerr");
    do_read(1'b1, 16'h0000, "status_parerr_clr");
    do_read(1'b0, 16'h0000, "rd_after_parerr");
`else
    send_frame(8'h1C, 1'b1, 1'b1);
    do_read(1'b0, 16'h801C, "rd_par_ignored");
`endif

    // overflow: nine frames into eight entries
    for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
    do_read(1'b1, 16'h8008, "status_ovf");
    for (int i = 1; i <= 8; i++) do_read(1'b0, 16'h8000 | 16'(i), "rd_ovf_seq");
    do_read(1'b0, 16'h0000, "rd_empty");
    do_read(1'b1, 16'h0000, "status_after_drain");

    // stop bit low drops the frame
    send_frame(8'h33, odd_par(8'h33), 1'b0);
    do_read(1'b1, 16'h0000, "status_bad_stop");

    // partial frame abandoned by timeout, then a full frame
    send_partial(8'hA5, 4);
    tick(TO + 20);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    do_read(1'b1, 16'h0001, "status_timeout");
    do_read(1'b0, 16'h805A, "rd_5a");

    // reset in the middle of a frame
    send_partial(8'hFF, 3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_frame(8'h29, odd_par(8'h29), 1'b1);
    do_read(1'b1, 16'h0001, "status_after_reset");
    do_read(1'b0, 16'h8029, "rd_29");

    // full FIFO: pop coincident with push of 0x77
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), odd_par(8'h10 + 8'(i)), 1'b1);
    last_stop = -1;
    fork
      send_frame(8'h77, odd_par(8'h77), 1'b1);
      begin
        int guard = 0;
        while (last_stop < 0 && guard < 2000) begin tick(); guard++; end
        if (last_stop < 0) begin
          checks++; errors++;
          $display("FAIL stop_wait: stop bit never driven within %0d cycles", guard);
        end else begin
          while (cyc < last_stop + PUSH_LAT - 1) tick();
          do_read(1'b0, 16'h8010, "rd_coincident");
        end
      end
    join
    tick(4);
    do_read(1'b1, 16'h0008, "status_full_nopush_loss");
    for (int i = 1; i < 8; i++) do_read(1'b0, 16'h8010 | 16'(i), "rd_full_seq");
    do_read(1'b0, 16'h8077, "rd_77_last");
    do_read(1'b0, 16'h0000, "rd_final_empty");
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_port.md
PS2_KEYBOARD_PORT -- requirements
Module: ps2_keyboard_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: scancode FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: Clock cycles without a PS2 clock falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-003 Clock  input  1  system clock (CLOCK_50); all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 PS2_CLK  input  1  raw keyboard clock pin, asynchronous.
REQ-006 PS2_DAT  input  1  raw keyboard data pin, asynchronous.
REQ-007 ReadData  input  1  bus read strobe, one cycle per access.
REQ-008 Addr  input  1  register select: 0 = DATA, 1 = STATUS.
REQ-009 DataOut  output  16  read data to the avalon bus mux.
REQ-010 DataDone  output  1  one-cycle read-complete pulse.
REQ-011 IrqPending  output  1  high while FIFO is non-empty.

Function
REQ-012 PS2_CLK and PS2_DAT shall each pass through a 2-flop synchronizer; a falling edge is synchronized clock 1 -> 0 between consecutive cycles.
REQ-013 Receive FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on a falling edge except the timeout.
REQ-014 IDLE: data sampled 0 -> DATA with bit counter cleared; data 1 -> stay IDLE.
REQ-015 DATA: shift sampled bit into shift register LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture bit -> STOP.
REQ-017 STOP: data 1 -> frame valid, push attempted, -> IDLE; data 0 -> frame dropped, -> IDLE.
REQ-018 Timeout counter shall clear on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE shall discard the partial frame and force IDLE.
REQ-019 Push shall occur the cycle after the stop-bit edge; FIFO full at push -> frame dropped, sticky Overflow set, FIFO contents unchanged.
REQ-020 DATA read: DataOut = {1'b1, 7'b0, scancode} and pop when non-empty; DataOut = 16'h0000 and no pop when empty.
REQ-021 STATUS read: DataOut = {Overflow, ParErr, 7'b0, count[6:0]}; no pop; clears Overflow and ParErr in the same cycle they are reported.
REQ-022 Read latency exactly 1 cycle: DataOut valid and DataDone = 1 in the cycle after ReadData = 1; otherwise DataDone = 0 and DataOut holds its last value.
REQ-023 Simultaneous push and pop on a full FIFO shall both succeed, count unchanged, no overflow.
REQ-024 Simultaneous push and pop on an empty FIFO: the read returns 16'h0000 and the push is stored.
REQ-025 Simultaneous flag set and STATUS clear: set wins (flag reads 1 next time).
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-027 ReadData asserted on consecutive cycles shall produce one response per request, in order.

Reset
REQ-028 Reset = 0 at a rising edge shall force FSM to IDLE, pointers, count, timeout and bit counters to 0, Overflow = 0, ParErr = 0, DataOut = 16'h0000, DataDone = 0, IrqPending = 0.
REQ-029 Reset mid-frame shall discard the partial frame; reception resumes with the next start bit after release.
REQ-030 Synchronizer flops shall reset to 1 (idle bus level), so release produces no false edge.

Configuration
REQ-031 Macro PS2_PARITY_CHECK_EN defined: frames whose 8 data bits plus parity bit have even parity shall be dropped and set sticky ParErr.
REQ-032 PS2_PARITY_CHECK_EN undefined: parity bit captured but ignored; ParErr reads constant 0; only the stop bit qualifies a frame.

Verification
REQ-033 Reset; send frame 0x1C (parity 0, stop 1); DATA read -> DataOut = 16'h801C, DataDone 1 cycle after ReadData, IrqPending falls.
REQ-034 Send 9 frames 0x01..0x09 with depth 8, no reads; STATUS -> 16'h8008; 8 DATA reads -> 0x8001..0x8008; 9th read -> 16'h0000.
REQ-035 With PS2_PARITY_CHECK_EN, send 0x1C with parity 1 -> FIFO stays empty, STATUS -> 16'h4000; second STATUS -> 16'h0000.
REQ-036 Send start + 4 data bits, then idle TIMEOUT_CYCLES cycles, then full frame 0x5A -> exactly one entry, 16'h805A.
REQ-037 FIFO full; DATA read coincident with push of 0x77 -> count stays 8, no overflow, 0x77 read 8th.
REQ-038 Assert Reset mid-frame after 3 data bits, release, send 0x29 -> single entry 16'h8029.
